sdf_bf_stage4: RTL and testbench

SDF_BF_STAGE4 -- requirements
Module: sdf_bf_stage4

---
 rtl/sdf_bf_stage4.sv | 151 +++++++++++++++
 tb/tb_sdf_bf_stage4.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sdf_bf_stage4.sv
// sdf_bf_stage4 -- one radix-2 single-path delay-feedback (SDF) FFT stage
// with a 4-entry complex feedback delay line.
//
// The phase input comes from the stage twiddle ROM, and that input alone
// sequences the block. The block keeps no phase counter of its own.
//   state | meaning
//   0     | fill: push din into the delay line, dout held, out_valid low
//   1     | butterfly: dout = head + din, push head - din
//   2     | twiddle: dout = head * w, push din
//   3     | treated as fill
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   in_valid              input sample valid (din taken as 0 when low)
//   din_r, din_i  [23:0]  complex input sample, two's complement
//   w_r, w_i      [23:0]  twiddle, 8 fractional bits (256 = 1.0)
//   state         [1:0]   stage phase
//   dout_r, dout_i [23:0] registered complex output
//   out_valid             registered, high when dout carries a stage output
//
// Build option: define SDF_BF_ROUND_EN to round the twiddle product half up
// (add 128 before the shift). When it is undefined, the product is truncated.

module sdf_bf_stage4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [23:0] din_r,
  input  logic [23:0] din_i,
  input  logic [23:0] w_r,
  input  logic [23:0] w_i,
  input  logic [1:0]  state,
  output logic [23:0] dout_r,
  output logic [23:0] dout_i,
  output logic        out_valid
);

  localparam logic [1:0] PH_FILL = 2'd0;
  localparam logic [1:0] PH_BFLY = 2'd1;
  localparam logic [1:0] PH_TWID = 2'd2;

  logic [23:0] dly_r_q [4];
  logic [23:0] dly_i_q [4];
  logic [23:0] dly_r_d [4];
  logic [23:0] dly_i_d [4];
  logic [23:0] dout_r_q, dout_r_d;
  logic [23:0] dout_i_q, dout_i_d;
  logic        out_valid_q, out_valid_d;

  logic [1:0]  phase;
  logic        advance;
  logic [23:0] x_r, x_i;
  logic [23:0] push_r, push_i;

  assign phase   = (state == 2'd3) ? PH_FILL : state;
  assign advance = in_valid || (phase != PH_FILL);
  // A flush cycle (advancing without a valid sample) pushes zeros.
  assign x_r     = in_valid ? din_r : 24'd0;
  assign x_i     = in_valid ? din_i : 24'd0;

  // Full-precision complex product of the head entry and the twiddle.
  logic signed [23:0] h_r_s, h_i_s, w_r_s, w_i_s;
  logic signed [47:0] p_rr, p_ii, p_ri, p_ir;
  logic        [48:0] re_full, im_full;
  logic        [48:0] re_rnd, im_rnd;
  logic               unused_prod_bits;

  assign h_r_s = dly_r_q[0];
  assign h_i_s = dly_i_q[0];
  assign w_r_s = w_r;
  assign w_i_s = w_i;
  assign p_rr  = w_r_s * h_r_s;
  assign p_ii  = w_i_s * h_i_s;
  assign p_ri  = w_r_s * h_i_s;
  assign p_ir  = w_i_s * h_r_s;

  assign re_full = {p_rr[47], p_rr} - {p_ii[47], p_ii};
  assign im_full = {p_ri[47], p_ri} + {p_ir[47], p_ir};

`ifdef SDF_BF_ROUND_EN
  assign re_rnd = re_full + 49'd128;
  assign im_rnd = im_full + 49'd128;
`else
  assign re_rnd = re_full;
  assign im_rnd = im_full;
`endif

  // Bits [31:8] are the arithmetic shift right by 8, truncated to 24 bits.
  assign unused_prod_bits = ^{re_rnd[48:32], re_rnd[7:0], im_rnd[48:32], im_rnd[7:0]};

  always_comb begin
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    out_valid_d = 1'b0;
    push_r      = x_r;
    push_i      = x_i;
    for (int k = 0; k < 4; k++) begin
      dly_r_d[k] = dly_r_q[k];
      dly_i_d[k] = dly_i_q[k];
    end

    if (advance) begin
      case (phase)
        PH_BFLY: begin
          dout_r_d    = dly_r_q[0] + x_r;
          dout_i_d    = dly_i_q[0] + x_i;
          push_r      = dly_r_q[0] - x_r;
          push_i      = dly_i_q[0] - x_i;
          out_valid_d = 1'b1;
        end
        PH_TWID: begin
          dout_r_d    = re_rnd[31:8];
          dout_i_d    = im_rnd[31:8];
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
      for (int k = 0; k < 3; k++) begin
        dly_r_d[k] = dly_r_q[k+1];
        dly_i_d[k] = dly_i_q[k+1];
      end
      dly_r_d[3] = push_r;
      dly_i_d[3] = push_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        dly_r_q[k] <= 24'd0;
        dly_i_q[k] <= 24'd0;
      end
      dout_r_q    <= 24'd0;
      dout_i_q    <= 24'd0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        dly_r_q[k] <= dly_r_d[k];
        dly_i_q[k] <= dly_i_d[k];
      end
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sdf_bf_stage4.sv
// tb_sdf_bf_stage4 -- self-checking bench for sdf_bf_stage4.
// A queue-based reference model is compared against the DUT on every cycle.
// Directed cases cover fill/butterfly, twiddle, wrap-around, stall and
// mid-frame reset. A randomized run follows them.

module tb_sdf_bf_stage4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
  logic [1:0]  state = '0;
  logic [23:0] dout_r, dout_i;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  sdf_bf_stage4 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .din_r(din_r), .din_i(din_i), .w_r(w_r), .w_i(w_i), .state(state),
    .dout_r(dout_r), .dout_i(dout_i), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: the delay line is a FIFO of signed complex values.
  longint q_r[$], q_i[$];
  longint exp_r, exp_i;
  bit     exp_v;

  function automatic longint sx24(longint v);
    logic [23:0] t;
    t = v[23:0];
    return longint'($signed(t));
  endfunction

  function automatic longint u24(longint v);
    return v & 64'hFF_FFFF;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_r.delete(); q_i.delete();
    repeat (4) begin q_r.push_back(0); q_i.push_back(0); end
    exp_r = 0; exp_i = 0; exp_v = 0;
  endtask

  task automatic model_step(input bit v, input int st_in, input longint dr, input longint di,
                            input longint wr, input longint wi);
    int st;
    longint xr, xi, hr, hi, pr, pi;
    st = (st_in == 3) ? 0 : st_in;
    xr = v ? dr : 0;
    xi = v ? di : 0;
    if (!(v || st != 0)) begin
      exp_v = 0;
      return;
    end
    hr = q_r.pop_front();
    hi = q_i.pop_front();
    if (st == 0) begin
      q_r.push_back(xr); q_i.push_back(xi);
      exp_v = 0;
    end else if (st == 1) begin
      exp_r = sx24(hr + xr); exp_i = sx24(hi + xi);
      q_r.push_back(sx24(hr - xr)); q_i.push_back(sx24(hi - xi));
      exp_v = 1;
    end else begin
      pr = wr * hr - wi * hi;
      pi = wr * hi + wi * hr;
`ifdef SDF_BF_ROUND_EN
      pr += 128; pi += 128;
`endif
      exp_r = sx24(pr >>> 8); exp_i = sx24(pi >>> 8);
      q_r.push_back(xr); q_i.push_back(xi);
      exp_v = 1;
    end
  endtask

  // Drive one cycle (inputs set away from the edge), then compare after the edge.
  task automatic step(input bit v, input int st, input longint dr, input longint di,
                      input longint wr, input longint wi, input string tag);
    in_valid = v;
    state    = 2'(st);
    din_r    = dr[23:0];
    din_i    = di[23:0];
    w_r      = wr[23:0];
    w_i      = wi[23:0];
    @(posedge clk);
    #1;
    model_step(v, st, sx24(dr), sx24(di), sx24(wr), sx24(wi));
    chk({tag, ".dout_r"}, longint'(dout_r), u24(exp_r));
    chk({tag, ".dout_i"}, longint'(dout_i), u24(exp_i));
    chk({tag, ".out_valid"}, longint'(out_valid), longint'(exp_v));
  endtask

  task automatic fill_and_butterfly(input string tag);
    for (int k = 1; k <= 4; k++) step(1, 0, k, 0, 0, 0, {tag, ".fill"});
    for (int k = 5; k <= 8; k++) begin
      step(1, 1, k, 0, 0, 0, {tag, ".bfly"});
      chk({tag, ".bfly_const_r"}, longint'(dout_r), longint'(2 * k - 4));
      chk({tag, ".bfly_const_i"}, longint'(dout_i), 0);
    end
  endtask

  longint tw_wr[4] = '{256, 181, 0, -181};
  longint tw_wi[4] = '{0, -181, -256, -181};
`ifdef SDF_BF_ROUND_EN
  longint tw_er[4] = '{-4, -3, 0, 3};
  longint tw_ei[4] = '{0, 3, 4, 3};
`else
  longint tw_er[4] = '{-4, -3, 0, 2};
  longint tw_ei[4] = '{0, 2, 4, 2};
`endif

  initial begin
    model_reset();
    #12;
    chk("reset.dout_r", longint'(dout_r), 0);
    chk("reset.dout_i", longint'(dout_i), 0);
    chk("reset.out_valid", longint'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    fill_and_butterfly("fb");
    for (int k = 0; k < 4; k++) begin
      step(1, 2, 0, 0, tw_wr[k], tw_wi[k], "twid");
      chk("twid_const_r", longint'(dout_r), u24(tw_er[k]));
      chk("twid_const_i", longint'(dout_i), u24(tw_ei[k]));
    end

    // Wrap-around: head 0x7FFFFF, din 1.
    step(1, 0, 64'h7FFFFF, 0, 0, 0, "wrap.fill");
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, "wrap.fill");
    step(1, 1, 1, 0, 0, 0, "wrap.bfly");
    chk("wrap_sum", longint'(dout_r), 64'h800000);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, "wrap.bfly");
    step(1, 2, 0, 0, 256, 0, "wrap.twid");
    chk("wrap_pushed", longint'(dout_r), 64'h7FFFFE);

    // Stall mid-fill, then butterfly reveals the delay line was untouched.
    step(1, 0, 11, 21, 0, 0, "stall.fill");
    step(1, 0, 12, 22, 0, 0, "stall.fill");
    for (int k = 0; k < 5; k++) begin
      step(0, 0, $urandom, $urandom, $urandom, $urandom, "stall.hold");
      chk("stall_valid", longint'(out_valid), 0);
    end
    step(1, 0, 13, 23, 0, 0, "stall.fill");
    step(1, 0, 14, 24, 0, 0, "stall.fill");
    step(1, 1, 0, 0, 0, 0, "stall.bfly");
    chk("stall_head", longint'(dout_r), 11);

    // Reset asserted during a twiddle cycle.
    in_valid = 1; state = 2; w_r = 24'd256; w_i = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.dout_r", longint'(dout_r), 0);
    chk("midrst.out_valid", longint'(out_valid), 0);
    @(posedge clk); #1;
    chk("midrst_hold.dout_r", longint'(dout_r), 0);
    chk("midrst_hold.out_valid", longint'(out_valid), 0);
    rst_n = 1'b1;
    fill_and_butterfly("refill");

    // Randomized run.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 3),
           longint'($urandom), longint'($urandom),
           longint'($urandom), longint'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
